// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions.
//   - sched_state_e : sequencer states of encoder_sample_scheduler
//   - DEF_POS_W / DEF_VEL_W : default position / velocity widths
//   - sat_clamp()   : signed saturating clamp to a w-bit range (also used by the PI block)
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT_TICK,
        ST_COMPUTE,
        ST_PRESENT
    } sched_state_e;

    localparam int unsigned DEF_POS_W = 32;
    localparam int unsigned DEF_VEL_W = 16;

    // Clamp x into [-2^(w-1), 2^(w-1)-1]; caller keeps w in 2..63.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                     input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   restart : synchronous; holds the count at 0 (and suppresses tick) while high
//   tick    : one-cycle pulse on the cycle the count sits at DIV-1 (the wrap)
module sample_tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/encoder_sample_scheduler.sv
// Periodic encoder sampler feeding the PI velocity loop.
//   clk, reset          : system clock, asynchronous active-high reset
//   enable              : level run request; low returns to IDLE and drops any pending sample
//   position            : signed encoder count
//   zero_req            : pulse; current position becomes the pos_out reference
//   clear_overrun       : pulse; clears overrun and missed_cnt
//   sample_ready        : consumer handshake
//   sample_valid        : sample pending (held until accepted)
//   vel_out / vel_sat   : saturated one-period position delta and its clamp flag
//   pos_out             : position relative to the zero reference
//   overrun, missed_cnt : sticky miss flag and saturating miss counter
module encoder_sample_scheduler
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned POS_W      = DEF_POS_W,
    parameter int unsigned VEL_W      = DEF_VEL_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [POS_W-1:0] position,
    input  logic                    zero_req,
    input  logic                    clear_overrun,
    input  logic                    sample_ready,
    output logic                    sample_valid,
    output logic signed [VEL_W-1:0] vel_out,
    output logic                    vel_sat,
    output logic signed [POS_W-1:0] pos_out,
    output logic                    overrun,
    output logic [7:0]              missed_cnt
);

    sched_state_e state_q, state_d;

    logic signed [POS_W-1:0] prev_q, prev_d;
    logic signed [POS_W-1:0] snap_q, snap_d;
    logic signed [POS_W-1:0] offset_q, offset_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    sat_q, sat_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic [7:0]              missed_q, missed_d;

    logic                    tick;
    logic                    restart;
    logic                    miss;
    logic signed [POS_W:0]   diff;
    logic signed [63:0]      diff_ext;
    logic signed [63:0]      clamped;

    // Divider is held at 0 in IDLE and restarted in PRIME, so the first tick
    // lands one full period after priming.
    assign restart = (state_q == ST_IDLE) || (state_q == ST_PRIME);

    sample_tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // One extra bit keeps the subtraction exact; counter wrap shows up as saturation.
    assign diff     = {snap_q[POS_W-1], snap_q} - {prev_q[POS_W-1], prev_q};
    assign diff_ext = 64'(diff);
    assign clamped  = sat_clamp(diff_ext, VEL_W);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        snap_d  = snap_q;
        vel_d   = vel_q;
        sat_d   = sat_q;
        pos_d   = pos_q;
        miss    = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_PRIME;
                ST_PRIME: begin
                    prev_d  = position;
                    state_d = ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (tick) begin
                        snap_d  = position;
                        state_d = ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    vel_d   = clamped[VEL_W-1:0];
                    sat_d   = (clamped != diff_ext);
                    pos_d   = snap_q - offset_q;
                    prev_d  = snap_q;
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (sample_ready) begin
                        // Accept and tick together: capture as if already waiting.
                        if (tick) begin
                            snap_d  = position;
                            state_d = ST_COMPUTE;
                        end else begin
                            state_d = ST_WAIT_TICK;
                        end
                    end else if (tick) begin
                        // Missed period: keep the pending sample, re-base the
                        // next velocity so it still spans exactly one period.
                        prev_d = position;
                        miss   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        valid_d = (state_d == ST_PRESENT);
    end

    always_comb begin
        offset_d  = zero_req ? position : offset_q;
        overrun_d = clear_overrun ? 1'b0 : overrun_q;
        missed_d  = clear_overrun ? '0 : missed_q;
        // A new miss overrides a simultaneous clear.
        if (miss) begin
            overrun_d = 1'b1;
            if (missed_d != 8'hFF) begin
                missed_d = missed_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            snap_q    <= '0;
            offset_q  <= '0;
            pos_q     <= '0;
            vel_q     <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            missed_q  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            snap_q    <= snap_d;
            offset_q  <= offset_d;
            pos_q     <= pos_d;
            vel_q     <= vel_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            missed_q  <= missed_d;
        end
    end

    assign sample_valid = valid_q;
    assign vel_out      = vel_q;
    assign vel_sat      = sat_q;
    assign pos_out      = pos_q;
    assign overrun      = overrun_q;
    assign missed_cnt   = missed_q;

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// Scoreboard bench for encoder_sample_scheduler with SAMPLE_DIV=10.
// Stimulus is grouped into 10-cycle blocks aligned so the last position of
// each block is the one captured at the tick; expected samples are pushed
// before each block and popped by the monitor on every accepted transfer.
module tb_encoder_sample_scheduler;

    localparam int unsigned DIV = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [31:0] position;
    logic               zero_req;
    logic               clear_overrun;
    logic               sample_ready;
    logic               sample_valid;
    logic signed [15:0] vel_out;
    logic               vel_sat;
    logic signed [31:0] pos_out;
    logic               overrun;
    logic [7:0]         missed_cnt;

    typedef struct packed {
        logic signed [15:0] vel;
        logic               sat;
        logic signed [31:0] pos;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   valid_seen = 0;
    int   base;

    always #5 clk = ~clk;

    encoder_sample_scheduler #(
        .SAMPLE_DIV (DIV),
        .POS_W      (32),
        .VEL_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .position      (position),
        .zero_req      (zero_req),
        .clear_overrun (clear_overrun),
        .sample_ready  (sample_ready),
        .sample_valid  (sample_valid),
        .vel_out       (vel_out),
        .vel_sat       (vel_sat),
        .pos_out       (pos_out),
        .overrun       (overrun),
        .missed_cnt    (missed_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int v, input logic s, input int p);
        sb.push_back('{vel: 16'(v), sat: s, pos: p});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample period of stimulus: position moves by rate each cycle.
    // rdy_at / clr_at select the cycle (1..10) at which sample_ready is
    // changed / clear_overrun is pulsed; zq pulses zero_req on the capture cycle.
    task automatic blk(input int rate, input int rdy_at, input logic rdy_val,
                       input logic zq, input int clr_at);
        for (int i = 1; i <= 10; i++) begin
            step();
            position      = position + rate;
            zero_req      = (i == 10) ? zq : 1'b0;
            clear_overrun = (i == clr_at);
            if (i == rdy_at) sample_ready = rdy_val;
        end
    endtask

    // Monitor: compare every accepted sample against the scoreboard.
    always @(negedge clk) begin
        if (sample_valid) valid_seen <= valid_seen + 1;
        if (!reset && sample_valid && sample_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got vel=%0d pos=%0d expected none",
                         vel_out, pos_out);
            end else begin
                mon_e = sb.pop_front();
                chk("sample_vel", vel_out, mon_e.vel);
                chk("sample_sat", vel_sat, mon_e.sat);
                chk("sample_pos", pos_out, mon_e.pos);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        position      = 0;
        zero_req      = 1'b0;
        clear_overrun = 1'b0;
        sample_ready  = 1'b1;

        step();
        chk("rst_valid",   sample_valid, 0);
        chk("rst_vel",     vel_out, 0);
        chk("rst_sat",     vel_sat, 0);
        chk("rst_pos",     pos_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_missed",  missed_cnt, 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("idle_valid", sample_valid, 0);

        // Enable, then the PRIME cycle samples 1000 as the first reference.
        step(); enable = 1'b1; position = 1000;
        step(); position = 1000;

        push(30, 0, 1030);      blk(3, -1, 1'b1, 1'b0, -1);
        push(30, 0, 1060);      blk(3, -1, 1'b1, 1'b0, -1);
        push(30, 0, 1090);      blk(3, -1, 1'b1, 1'b0, -1);
        push(32767, 1, 41090);  blk(4000, -1, 1'b1, 1'b0, -1);
        push(-32768, 1, 1090);  blk(-4000, -1, 1'b1, 1'b0, -1);

        // Consumer stalls across two ticks; sample 1100/10 must be held.
        push(10, 0, 1100);      blk(1, 10, 1'b0, 1'b0, -1);
        blk(2, -1, 1'b1, 1'b0, -1);
        blk(2, -1, 1'b1, 1'b0, -1);
        chk("held_valid", sample_valid, 1);
        chk("held_vel",   vel_out, 10);
        // Next velocity spans only the last period: 1190 - 1140.
        push(50, 0, 1190);      blk(5, 5, 1'b1, 1'b0, -1);
        chk("overrun_set", overrun, 1);
        chk("missed_two",  missed_cnt, 2);

        // Clear overrun; zero_req coincides with capture at 500.
        push(-690, 0, 0);       blk(-69, -1, 1'b1, 1'b1, 1);
        chk("overrun_clr", overrun, 0);
        chk("missed_clr",  missed_cnt, 0);
        push(20, 0, 20);        blk(2, -1, 1'b1, 1'b0, -1);

        // Sample 530 presented but never accepted; enable drops.
        blk(1, 5, 1'b0, 1'b0, -1);
        step();
        step();
        chk("pend_valid", sample_valid, 1);
        chk("pend_vel",   vel_out, 10);
        enable = 1'b0;
        step();
        chk("disable_valid", sample_valid, 0);
        sample_ready = 1'b1;

        // Re-enable: no sample for a full period; zero offset 500 is retained.
        step(); enable = 1'b1; position = 600;
        base = valid_seen;
        step(); position = 600;
        push(-30, 0, 70);
        for (int i = 1; i <= 10; i++) begin
            step();
            position = position - 3;
        end
        chk("reprime_no_valid", valid_seen - base, 0);
        blk(-3, -1, 1'b1, 1'b0, -1);

        // Capture of 540 happens at the next edge; reset lands in COMPUTE.
        step();
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_valid",   sample_valid, 0);
        chk("async_vel",     vel_out, 0);
        chk("async_sat",     vel_sat, 0);
        chk("async_pos",     pos_out, 0);
        chk("async_overrun", overrun, 0);
        chk("async_missed",  missed_cnt, 0);
        step();
        step();
        reset = 1'b0;
        base = valid_seen;
        repeat (25) step();
        chk("post_reset_idle", valid_seen - base, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
